game_ctrl: RTL and testbench

Top-level game sequencer for the runner game. It owns the game-mode state machine (initial / in-game / paused / ended), generates the per-frame update strobe that advances the player and obstacle datapaths, and scans all 10 obstacles against the player box after every frame to detect a crash. Its `gamemode` output replaces the switch-OR-crash mode logic in the player datapath and drives the renderer.

---
 rtl/game_ctrl_if.sv | 23 ++
 rtl/game_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Bus between the game sequencer and the player/obstacle/render side.
// Inputs are switches and datapath geometry; outputs are mode, frame strobe and scan results.
interface game_ctrl_if;
   logic [2:0]   sw;
   logic [8:0]   player_y;
   logic [199:0] obstacle_x;
   logic [179:0] obstacle_y;
   logic [1:0]   gamemode;
   logic         update_en;
   logic         scan_busy;
   logic [3:0]   crash_idx;
   logic [15:0]  score;

   modport master (
      output sw, player_y, obstacle_x, obstacle_y,
      input  gamemode, update_en, scan_busy, crash_idx, score
   );

   modport slave (
      input  sw, player_y, obstacle_x, obstacle_y,
      output gamemode, update_en, scan_busy, crash_idx, score
   );
endinterface

// File: rtl/game_ctrl.sv
// Runner-game sequencer: mode FSM, frame strobe and per-frame obstacle collision scan.
// Define GAME_CTRL_GODMODE_EN to keep scanning but never end the game on a crash.
module game_ctrl #(
   parameter int unsigned FRAME_DIV   = 833333,
   parameter int unsigned PLAYER_X    = 100,
   parameter int unsigned PLAYER_SIZE = 40,
   parameter int unsigned N_OBS       = 10
) (
   input logic        clk,
   input logic        rst_n,
   game_ctrl_if.slave bus
);
   localparam int unsigned     DW      = $clog2(FRAME_DIV);
   localparam logic [DW-1:0]   DIV_MAX = DW'(FRAME_DIV - 1);
   localparam logic [10:0]     P_LEFT  = 11'(PLAYER_X);
   localparam logic [10:0]     P_RIGHT = 11'(PLAYER_X + PLAYER_SIZE);
   localparam logic [10:0]     P_SIZE  = 11'(PLAYER_SIZE);
   localparam logic [3:0]      NO_HIT  = 4'hF;
   localparam logic [3:0]      LAST_K  = 4'(N_OBS - 1);
`ifdef GAME_CTRL_GODMODE_EN
   localparam bit GODMODE = 1'b1;
`else
   localparam bit GODMODE = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t        state, run_next;
   logic [DW-1:0] div;
   logic [3:0]    k;
   logic          hit;
   logic          update_en, scan_busy;
   logic [3:0]    crash_idx;
   logic [15:0]   score;

   logic [9:0]    x_left, x_right;
   logic [8:0]    y_top, y_bottom;
   logic          hit_now, scan_hit, scan_done, scan_abort, scan_start;

   // sw[0] belongs to the player datapath
   logic          unused_sw0;
   assign unused_sw0 = bus.sw[0];

   always_comb begin
      x_left   = '0;
      x_right  = '0;
      y_top    = '0;
      y_bottom = '0;
      for (int unsigned i = 0; i < N_OBS; i++) begin
         if (k == 4'(i)) begin
            x_left   = bus.obstacle_x[20*i +: 10];
            x_right  = bus.obstacle_x[20*i+10 +: 10];
            y_top    = bus.obstacle_y[18*i +: 9];
            y_bottom = bus.obstacle_y[18*i+9 +: 9];
         end
      end
   end

   assign hit_now = (x_left != x_right)
                  && ({1'b0, x_left} < P_RIGHT) && (P_LEFT < {1'b0, x_right})
                  && ({2'b0, y_top} < {2'b0, bus.player_y} + P_SIZE)
                  && ({2'b0, bus.player_y} < {2'b0, y_bottom});
   assign scan_hit  = hit | hit_now;
   assign scan_done = scan_busy && (k == LAST_K);

   always_comb begin
      run_next = RUN;
      if (scan_done && scan_hit && !GODMODE) run_next = OVER;
      else if (!bus.sw[1])                   run_next = IDLE;
      else if (bus.sw[2])                    run_next = PAUSE;
   end

   // A frame strobe that coincides with leaving RUN starts no scan
   assign scan_abort = (state == RUN) && scan_busy && (run_next == IDLE || run_next == PAUSE);
   assign scan_start = (state == RUN) && update_en && (run_next == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         div       <= '0;
         update_en <= 1'b0;
         scan_busy <= 1'b0;
         k         <= '0;
         hit       <= 1'b0;
         crash_idx <= NO_HIT;
         score     <= '0;
      end else begin
         case (state)
            IDLE: if (bus.sw[1] && !bus.sw[2]) begin
               state <= RUN;
               score <= '0;
            end
            RUN:   state <= run_next;
            PAUSE: if (!bus.sw[1]) state <= IDLE;
                   else if (!bus.sw[2]) state <= RUN;
            OVER:  if (!bus.sw[1]) state <= IDLE;
            default: state <= IDLE;
         endcase

         case (state)
            RUN:     div <= (div == DIV_MAX) ? '0 : div + DW'(1);
            PAUSE:   div <= div;
            default: div <= '0;
         endcase
         update_en <= (state == RUN) && (div == DIV_MAX);

         if (scan_abort) begin
            scan_busy <= 1'b0;
            k         <= '0;
            hit       <= 1'b0;
            crash_idx <= NO_HIT;
         end else if (scan_start) begin
            scan_busy <= 1'b1;
            k         <= '0;
            hit       <= 1'b0;
            crash_idx <= NO_HIT;
         end else if (scan_busy) begin
            if (hit_now && !hit) crash_idx <= k;
            hit <= scan_hit;
            if (scan_done) begin
               scan_busy <= 1'b0;
               k         <= '0;
               if ((GODMODE || !scan_hit) && (score != '1)) score <= score + 16'd1;
            end else begin
               k <= k + 4'd1;
            end
         end
      end
   end

   assign bus.gamemode  = state;
   assign bus.update_en = update_en;
   assign bus.scan_busy = scan_busy;
   assign bus.crash_idx = crash_idx;
   assign bus.score     = score;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with hand-derived timing and values.
module tb_game_ctrl;
   localparam int F  = 16;
   localparam int PX = 100;
   localparam int PS = 40;
`ifdef GAME_CTRL_GODMODE_EN
   localparam bit GOD = 1'b1;
`else
   localparam bit GOD = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   game_ctrl_if bus();

   game_ctrl #(
      .FRAME_DIV   (F),
      .PLAYER_X    (PX),
      .PLAYER_SIZE (PS),
      .N_OBS       (10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int xl[10], xr[10], yt[10], yb[10];
   int py;

   always_comb begin
      bus.obstacle_x = '0;
      bus.obstacle_y = '0;
      for (int i = 0; i < 10; i++) begin
         bus.obstacle_x[20*i +: 20] = {10'(xr[i]), 10'(xl[i])};
         bus.obstacle_y[18*i +: 18] = {9'(yb[i]), 9'(yt[i])};
      end
      bus.player_y = 9'(py);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: mode rules, frame counter, and a scan that knows the
   // first overlapping obstacle up front and reveals it when the scan reaches it.
   int m_mode = 0, m_div = 0, m_pos = 0, m_first = 15, m_crash = 15, m_score = 0;
   bit m_upd = 0, m_busy = 0;

   function automatic int first_hit();
      for (int i = 0; i < 10; i++)
         if (xl[i] != xr[i] && xl[i] < PX + PS && PX < xr[i] && yt[i] < py + PS && py < yb[i])
            return i;
      return 15;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int  mode_n;
      bit  done, sw1, sw2;
      if (!rst_n) begin
         m_mode = 0; m_div = 0; m_pos = 0; m_first = 15; m_crash = 15;
         m_score = 0; m_upd = 0; m_busy = 0;
      end else begin
         sw1    = bus.sw[1];
         sw2    = bus.sw[2];
         done   = m_busy && m_pos == 9;
         mode_n = m_mode;
         case (m_mode)
            0: if (sw1 && !sw2) begin mode_n = 1; m_score = 0; end
            1: if (done && m_first != 15 && !GOD) mode_n = 3;
               else if (!sw1) mode_n = 0;
               else if (sw2) mode_n = 2;
            2: if (!sw1) mode_n = 0; else if (!sw2) mode_n = 1;
            default: if (!sw1) mode_n = 0;
         endcase
         if (m_mode == 1 && mode_n != 1 && mode_n != 3 && m_busy) begin
            m_busy = 0; m_pos = 0; m_crash = 15;
         end else if (m_busy) begin
            if (m_pos == m_first) m_crash = m_first;
            if (done) begin
               m_busy = 0; m_pos = 0;
               if ((GOD || m_first == 15) && m_score < 65535) m_score++;
            end else m_pos++;
         end else if (m_upd && m_mode == 1 && mode_n == 1) begin
            m_busy = 1; m_pos = 0; m_crash = 15; m_first = first_hit();
         end
         m_upd = (m_mode == 1 && m_div == F - 1);
         if (m_mode == 1) m_div = (m_div + 1) % F;
         else if (m_mode != 2) m_div = 0;
         m_mode = mode_n;
      end
   end

   always @(negedge clk) begin
      chk("gamemode", int'(bus.gamemode), m_mode);
      chk("update_en", int'(bus.update_en), int'(m_upd));
      chk("scan_busy", int'(bus.scan_busy), int'(m_busy));
      chk("crash_idx", int'(bus.crash_idx), m_crash);
      chk("score", int'(bus.score), m_score);
   end

   task automatic wait_upd(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.update_en !== 1'b1 && n < 100);
      if (n >= 100) chk("update_timeout", n, 0);
   endtask

   task automatic set_obs(input int i, input int a, input int b, input int c, input int d);
      xl[i] = a; xr[i] = b; yt[i] = c; yb[i] = d;
   endtask

   int n, cnt;

   initial begin
      bus.sw = 3'b000;
      py = 0;
      for (int i = 0; i < 10; i++) set_obs(i, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_gamemode", int'(bus.gamemode), 0);
      chk("rst_update_en", int'(bus.update_en), 0);
      chk("rst_scan_busy", int'(bus.scan_busy), 0);
      chk("rst_crash_idx", int'(bus.crash_idx), 15);
      chk("rst_score", int'(bus.score), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // start; one far obstacle and one empty one that would otherwise overlap
      bus.sw = 3'b010;
      py = 100;
      set_obs(0, 140, 180, 100, 140);
      set_obs(1, 120, 120, 100, 140);
      @(negedge clk);
      chk("start_mode", int'(bus.gamemode), 1);
      wait_upd(n);  chk("first_frame_len", n, F);
      chk("score_f1", int'(bus.score), 0);
      wait_upd(n);  chk("frame_len", n, F);
      chk("score_f2", int'(bus.score), 1);
      wait_upd(n);
      chk("score_f3", int'(bus.score), 2);

      // pause with the divider at 5 (aborts the running scan)
      repeat (5) @(negedge clk);
      bus.sw = 3'b110;
      @(negedge clk);
      chk("pause_mode", int'(bus.gamemode), 2);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.update_en === 1'b1) cnt++;
      end
      chk("pause_strobes", cnt, 0);
      bus.sw = 3'b010;
      @(negedge clk);
      chk("resume_mode", int'(bus.gamemode), 1);
      wait_upd(n);  chk("resume_remaining", n, 10);
      chk("score_after_abort", int'(bus.score), 2);

      // crash against obstacle 3
      py = 210;
      set_obs(3, 120, 160, 200, 240);
      repeat (4) @(negedge clk);
      chk("crash_idx_T4", int'(bus.crash_idx), 15);
      @(negedge clk);
      chk("crash_idx_T5", int'(bus.crash_idx), 3);
      repeat (5) @(negedge clk);
      chk("mode_T10", int'(bus.gamemode), 1);
      chk("busy_T10", int'(bus.scan_busy), 1);
      @(negedge clk);
      chk("mode_T11", int'(bus.gamemode), GOD ? 1 : 3);
      chk("busy_T11", int'(bus.scan_busy), 0);
      chk("score_T11", int'(bus.score), GOD ? 3 : 2);
      repeat (20) @(negedge clk);
      chk("over_hold", int'(bus.gamemode), GOD ? 1 : 3);
      chk("crash_hold", int'(bus.crash_idx), 3);
      bus.sw = 3'b000;
      @(negedge clk);
      chk("back_idle", int'(bus.gamemode), 0);

      // pause during scan cycle 4 while obstacle 7 would hit
      set_obs(3, 0, 0, 0, 0);
      set_obs(7, 120, 160, 200, 240);
      bus.sw = 3'b010;
      @(negedge clk);
      chk("restart_mode", int'(bus.gamemode), 1);
      chk("restart_score", int'(bus.score), 0);
      wait_upd(n);
      repeat (4) @(negedge clk);
      bus.sw = 3'b110;
      @(negedge clk);
      chk("abort_mode", int'(bus.gamemode), 2);
      chk("abort_crash", int'(bus.crash_idx), 15);
      chk("abort_busy", int'(bus.scan_busy), 0);
      repeat (10) @(negedge clk);
      chk("abort_stay", int'(bus.gamemode), 2);
      bus.sw = 3'b000;
      @(negedge clk);
      chk("abort_idle", int'(bus.gamemode), 0);

      // asynchronous reset in the middle of a scan
      bus.sw = 3'b010;
      @(negedge clk);
      wait_upd(n);
      repeat (3) @(negedge clk);
      chk("mid_busy", int'(bus.scan_busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gamemode", int'(bus.gamemode), 0);
      chk("arst_busy", int'(bus.scan_busy), 0);
      chk("arst_crash", int'(bus.crash_idx), 15);
      chk("arst_update", int'(bus.update_en), 0);
      chk("arst_score", int'(bus.score), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
